// File: rtl/eth_tx_pkg.sv
// Shared constants, state encoding and frame-length helper for the Ethernet reply transmitter.
// ETH_TX_PAD_EN: when defined, short frames are zero-padded to the 60-byte Ethernet minimum.
package eth_tx_pkg;

    localparam logic [15:0] ETYPE_ARP       = 16'h0806;
    localparam logic [15:0] ETYPE_IP        = 16'h0800;
    localparam logic [15:0] ARP_OP_REPLY    = 16'h0002;
    localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
    localparam logic [15:0] ARP_HLEN_PLEN   = 16'h0604;
    localparam logic [15:0] IP_VER_IHL_TOS  = 16'h4500;
    localparam logic [7:0]  IP_PROTO_ICMP   = 8'h01;
    localparam logic [15:0] ICMP_TYPE_DELTA = 16'h0800;

    localparam int HDR_BYTES         = 42;
    localparam int MIN_FRAME_BYTES   = 60;
    localparam int IP_ICMP_HDR_BYTES = 28;
    localparam int LAST_HDR_WORD     = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSUM,
        ST_ARP,
        ST_HDR,
        ST_PAY,
        ST_DONE
    } tx_state_e;

    typedef struct packed {
        logic [10:0] last;       // index of the eop word
        logic [10:0] real_last;  // last word carrying frame bytes; beyond it only padding
        logic [1:0]  mod;
    } frame_len_t;

    function automatic frame_len_t frame_len(input logic [16:0] bytes);
        frame_len_t  f;
        logic [16:0] words;
        words       = (bytes + 17'd3) >> 2;
        f.real_last = 11'(words - 17'd1);
        f.last      = f.real_last;
        f.mod       = 2'(~bytes[1:0] + 2'd1);
`ifdef ETH_TX_PAD_EN
        if (bytes < 17'(MIN_FRAME_BYTES)) begin
            f.last = 11'(MIN_FRAME_BYTES / 4 - 1);
            f.mod  = 2'd0;
        end
`endif
        return f;
    endfunction

endpackage

// File: rtl/ip_csum16.sv
// Multi-operand 16-bit one's-complement adder: folds the carries back twice and also
// offers the inverted result for use as an IP/ICMP checksum field.
module ip_csum16 #(
    parameter int N = 2
) (
    input  logic [N-1:0][15:0] ops,
    output logic [15:0]        sum,
    output logic [15:0]        csum
);

    logic [31:0] acc;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) acc = acc + 32'(ops[i]);
        fold1 = 17'(acc[15:0]) + 17'(acc[31:16]);
        // after the first fold a carry leaves the low half small, so one more add settles it
        fold2 = fold1[15:0] + 16'(fold1[16]);
        sum   = fold2;
        csum  = ~fold2;
    end

endmodule

// File: rtl/eth_reply_tx.sv
// ARP / ICMP echo reply frame builder streaming 32-bit words to the MAC TX FIFO.
// ETH_TX_PAD_EN (see eth_tx_pkg::frame_len) selects zero padding of short frames to 60 bytes.
module eth_reply_tx
    import eth_tx_pkg::*;
#(
    parameter int         MAX_ICMP_LEN = 1472,
    parameter logic [7:0] IP_TTL       = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [7:0]  reply,
    input  logic [47:0] mac_my,
    input  logic [31:0] ip_my,
    input  logic [47:0] source_mac_ARP,
    input  logic [31:0] arp_peer_ip,
    input  logic [47:0] source_mac,
    input  logic [31:0] ICMP_IP_DEST,
    input  logic [15:0] identification,
    input  logic [15:0] identifier,
    input  logic [15:0] icmp_csum_rx,
    input  logic [15:0] icmp_length,
    output logic [10:0] mem_adr,
    input  logic [31:0] mem_data,
    output logic [31:0] tx_data,
    output logic        tx_wren,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic [1:0]  tx_mod,
    input  logic        tx_rdy,
    output logic        busy,
    output logic        done,
    output logic        drop
);

    tx_state_e   state, state_nx;
    logic [10:0] idx, idx_nx;
    logic        csum_ph;
    logic [47:0] dmac_q, mac_q;
    logic [31:0] ip_q, peer_q;
    logic [15:0] ident_q, icmp_id_q, len_q, icsum_q, hcsum_q;
    frame_len_t  flen_q;
    logic [31:0] cur_q;
    logic        adv_q;
    logic        drop_q;

    logic        req_icmp, len_ok, start_arp, start_icmp, start_drop, xfer;
    logic [15:0] ip_len, icsum_nx, icsum_inv, hcsum_nx, hsum_raw;
    frame_len_t  fl_arp, fl_icmp;
    logic [31:0] hdr_word, pay_word;
    logic        unused_bits;

    assign start_arp  = (state == ST_IDLE) && send && reply[0];
    assign req_icmp   = (state == ST_IDLE) && send && !reply[0] && reply[1];
    assign len_ok     = icmp_length <= 16'(MAX_ICMP_LEN);
    assign start_icmp = req_icmp && len_ok;
    assign start_drop = req_icmp && !len_ok;

    assign fl_arp  = frame_len(17'(HDR_BYTES));
    assign fl_icmp = frame_len(17'(HDR_BYTES) + {1'b0, icmp_length});
    assign ip_len  = len_q + 16'(IP_ICMP_HDR_BYTES);

    // Echo reply only changes the type byte 8 -> 0, so the checksum is patched, not recomputed.
    ip_csum16 #(.N(2)) u_icsum (
        .ops  ({icmp_csum_rx, ICMP_TYPE_DELTA}),
        .sum  (icsum_nx),
        .csum (icsum_inv)
    );

    // Zero-valued header fields (flags/fragment, checksum slot) are left out of the sum.
    ip_csum16 #(.N(8)) u_hcsum (
        .ops  ({IP_VER_IHL_TOS, ip_len, ident_q, {IP_TTL, IP_PROTO_ICMP},
                ip_q[31:16], ip_q[15:0], peer_q[31:16], peer_q[15:0]}),
        .sum  (hsum_raw),
        .csum (hcsum_nx)
    );

    assign unused_bits = &{1'b0, reply[7:2], icsum_inv, hsum_raw};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            csum_ph   <= 1'b0;
            dmac_q    <= '0;
            mac_q     <= '0;
            ip_q      <= '0;
            peer_q    <= '0;
            ident_q   <= '0;
            icmp_id_q <= '0;
            len_q     <= '0;
            icsum_q   <= '0;
            hcsum_q   <= '0;
            flen_q    <= '0;
            cur_q     <= '0;
            adv_q     <= 1'b0;
            drop_q    <= 1'b0;
            mem_adr   <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            drop_q <= start_drop;
            adv_q  <= xfer;
            if (state == ST_PAY) cur_q <= pay_word;
            if (state == ST_CSUM) begin
                csum_ph <= ~csum_ph;
                if (!csum_ph) hcsum_q <= hcsum_nx;
            end
            if (start_arp || start_icmp) begin
                dmac_q    <= reply[0] ? source_mac_ARP : source_mac;
                peer_q    <= reply[0] ? arp_peer_ip : ICMP_IP_DEST;
                mac_q     <= mac_my;
                ip_q      <= ip_my;
                ident_q   <= identification;
                icmp_id_q <= identifier;
                len_q     <= icmp_length;
                icsum_q   <= icsum_nx;
                flen_q    <= reply[0] ? fl_arp : fl_icmp;
                mem_adr   <= 11'd1;
            end else if (xfer) begin
                mem_adr <= mem_adr + 11'd1;
            end else if (state == ST_DONE) begin
                mem_adr <= '0;
            end
        end
    end

    assign tx_wren = (state == ST_ARP) || (state == ST_HDR) || (state == ST_PAY);
    assign xfer    = tx_wren && tx_rdy;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            ST_IDLE: begin
                idx_nx = '0;
                if (start_arp)       state_nx = ST_ARP;
                else if (start_icmp) state_nx = ST_CSUM;
            end
            ST_CSUM: if (csum_ph) state_nx = ST_HDR;
            ST_ARP, ST_PAY: begin
                if (xfer) begin
                    if (idx == flen_q.last) state_nx = ST_DONE;
                    else                    idx_nx   = idx + 11'd1;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    idx_nx = idx + 11'd1;
                    if (idx == 11'(LAST_HDR_WORD)) state_nx = ST_PAY;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        hdr_word = '0;
        case (idx)
            11'd0:  hdr_word = dmac_q[47:16];
            11'd1:  hdr_word = {dmac_q[15:0], mac_q[47:32]};
            11'd2:  hdr_word = mac_q[31:0];
            11'd3:  hdr_word = (state == ST_ARP) ? {ETYPE_ARP, ARP_HTYPE_ETH} : {ETYPE_IP, IP_VER_IHL_TOS};
            11'd4:  hdr_word = (state == ST_ARP) ? {ETYPE_IP, ARP_HLEN_PLEN} : {ip_len, ident_q};
            11'd5:  hdr_word = (state == ST_ARP) ? {ARP_OP_REPLY, mac_q[47:32]} : {16'h0000, IP_TTL, IP_PROTO_ICMP};
            11'd6:  hdr_word = (state == ST_ARP) ? mac_q[31:0] : {hcsum_q, ip_q[31:16]};
            11'd7:  hdr_word = (state == ST_ARP) ? ip_q : {ip_q[15:0], peer_q[31:16]};
            11'd8:  hdr_word = (state == ST_ARP) ? dmac_q[47:16] : {peer_q[15:0], 16'h0000};
            11'd9:  hdr_word = (state == ST_ARP) ? {dmac_q[15:0], peer_q[31:16]} : {icsum_q, icmp_id_q};
            11'd10: hdr_word = {peer_q[15:0], 16'h0000};
            default: hdr_word = '0;
        endcase
    end

    // mem_adr sits one word ahead; after a stall the read data has moved on, so the held copy is used.
    assign pay_word = (idx > flen_q.real_last) ? '0 : (adv_q ? mem_data : cur_q);

    assign tx_data = !tx_wren ? '0 : (state == ST_PAY) ? pay_word : hdr_word;
    assign tx_sop  = tx_wren && (idx == '0);
    assign tx_eop  = tx_wren && (idx == flen_q.last);
    assign tx_mod  = tx_eop ? flen_q.mod : 2'd0;
    assign busy    = state != ST_IDLE;
    assign done    = state == ST_DONE;
    assign drop    = drop_q;

endmodule

// File: tb/tb_eth_reply_tx.sv
// Scoreboard bench for eth_reply_tx: expected frame words are queued at send time and
// compared against the transferred words of the DUT.
module tb_eth_reply_tx;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
    } beat_t;

`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send = 1'b0;
    logic [7:0]  reply = 8'h00;
    logic [47:0] mac_my, source_mac_ARP, source_mac;
    logic [31:0] ip_my, arp_peer_ip, ICMP_IP_DEST;
    logic [15:0] identification, identifier, icmp_csum_rx, icmp_length;
    logic [10:0] mem_adr;
    logic [31:0] mem_data;
    logic [31:0] tx_data;
    logic        tx_wren, tx_sop, tx_eop, tx_rdy = 1'b1;
    logic [1:0]  tx_mod;
    logic        busy, done, drop;

    logic [31:0] mem [0:2047];
    beat_t       exp_q[$];
    beat_t       obs_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          sop_cyc;
    logic        done_after, timed_out, rnd_rdy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= mem[mem_adr];

    eth_reply_tx dut (
        .clk(clk), .rst(rst), .send(send), .reply(reply),
        .mac_my(mac_my), .ip_my(ip_my), .source_mac_ARP(source_mac_ARP),
        .arp_peer_ip(arp_peer_ip), .source_mac(source_mac), .ICMP_IP_DEST(ICMP_IP_DEST),
        .identification(identification), .identifier(identifier),
        .icmp_csum_rx(icmp_csum_rx), .icmp_length(icmp_length),
        .mem_adr(mem_adr), .mem_data(mem_data),
        .tx_data(tx_data), .tx_wren(tx_wren), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_mod(tx_mod), .tx_rdy(tx_rdy), .busy(busy), .done(done), .drop(drop)
    );

    task automatic set_defaults();
        mac_my         = 48'h0011_2233_4455;
        ip_my          = 32'hC0A8_0001;
        arp_peer_ip    = 32'hC0A8_0002;
        source_mac_ARP = 48'hAABB_CCDD_EEFF;
        source_mac     = 48'h0102_0304_0506;
        ICMP_IP_DEST   = 32'hC0A8_0003;
        identification = 16'h1234;
        identifier     = 16'hBEEF;
        icmp_csum_rx   = 16'hF7FE;
        icmp_length    = 16'd32;
    endtask

    task automatic push_word(input logic [31:0] d, input int i, input int n, input logic [1:0] m);
        beat_t b;
        b.d = d; b.sop = (i == 0); b.eop = (i == n - 1); b.mod = (i == n - 1) ? m : 2'd0;
        exp_q.push_back(b);
    endtask

    task automatic expect_arp();
        logic [31:0] w [0:10];
        int n;
        exp_q.delete();
        w[0]  = source_mac_ARP[47:16];
        w[1]  = {source_mac_ARP[15:0], mac_my[47:32]};
        w[2]  = mac_my[31:0];
        w[3]  = 32'h0806_0001;
        w[4]  = 32'h0800_0604;
        w[5]  = {16'h0002, mac_my[47:32]};
        w[6]  = mac_my[31:0];
        w[7]  = ip_my;
        w[8]  = source_mac_ARP[47:16];
        w[9]  = {source_mac_ARP[15:0], arp_peer_ip[31:16]};
        w[10] = {arp_peer_ip[15:0], 16'h0000};
        n = PAD ? 15 : 11;
        for (int i = 0; i < n; i++) push_word((i < 11) ? w[i] : 32'd0, i, n, PAD ? 2'd0 : 2'd2);
    endtask

    task automatic expect_icmp();
        logic [31:0] w [0:9];
        int tot, nreal, n;
        logic [1:0] m;
        logic [31:0] s;
        logic [15:0] hc, ic, ln;
        exp_q.delete();
        ln = icmp_length + 16'd28;
        s = 32'h4500 + ln + identification + 32'h4001 + ip_my[31:16] + ip_my[15:0]
            + ICMP_IP_DEST[31:16] + ICMP_IP_DEST[15:0];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        hc = ~s[15:0];
        s = icmp_csum_rx + 32'h0800;
        if (s > 32'hFFFF) s = s - 32'hFFFF;
        ic = s[15:0];
        w[0] = source_mac[47:16];
        w[1] = {source_mac[15:0], mac_my[47:32]};
        w[2] = mac_my[31:0];
        w[3] = 32'h0800_4500;
        w[4] = {ln, identification};
        w[5] = 32'h0000_4001;
        w[6] = {hc, ip_my[31:16]};
        w[7] = {ip_my[15:0], ICMP_IP_DEST[31:16]};
        w[8] = {ICMP_IP_DEST[15:0], 16'h0000};
        w[9] = {ic, identifier};
        tot   = 42 + int'(icmp_length);
        nreal = (tot + 3) / 4;
        n     = (PAD && tot < 60) ? 15 : nreal;
        m     = (PAD && tot < 60) ? 2'd0 : 2'((4 - tot % 4) % 4);
        for (int i = 0; i < n; i++)
            push_word((i < 10) ? w[i] : (i < nreal) ? mem[i] : 32'd0, i, n, m);
    endtask

    // Sends one request and records every transferred word; mess = disturb inputs mid-frame.
    task automatic run_frame(input int max_cyc, input bit mess);
        beat_t b;
        obs_q.delete(); sop_cyc = -1; done_after = 1'b0; timed_out = 1'b1;
        @(posedge clk); #1 send = 1'b1;
        @(posedge clk); #1 send = 1'b0;
        tx_rdy = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            if (tx_wren && tx_rdy) begin
                b.d = tx_data; b.sop = tx_sop; b.eop = tx_eop; b.mod = tx_mod;
                obs_q.push_back(b);
                if (tx_sop && sop_cyc < 0) sop_cyc = cyc;
                if (tx_eop) begin
                    @(posedge clk); #1 tx_rdy = 1'b1;
                    @(negedge clk); done_after = done; timed_out = 1'b0;
                    break;
                end
            end
            @(posedge clk); #1;
            tx_rdy = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            send   = mess && (cyc == 2);
            if (mess && cyc == 2) begin
                reply = 8'h02; mac_my = ~mac_my; ip_my = ~ip_my;
                source_mac_ARP = ~source_mac_ARP; arp_peer_ip = ~arp_peer_ip;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({tx_wren, tx_sop, tx_eop, tx_mod, busy, done, drop} !== 8'd0 || tx_data !== 32'd0 || mem_adr !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wren=%b sop=%b eop=%b mod=%0d busy=%b done=%b drop=%b data=%h adr=%0d, want all zero",
                     tx_wren, tx_sop, tx_eop, tx_mod, busy, done, drop, tx_data, mem_adr);
        end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_arp();
        set_defaults(); reply = 8'h01; rnd_rdy = 1'b0;
        expect_arp();
        run_frame(100, 1'b0);
        n_chk++; if (timed_out) begin n_fail++; $display("FAIL arp_timeout: no eop within 100 clks"); end
        n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL arp_words: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL arp_w%0d: got %h sop=%b eop=%b mod=%0d want %h sop=%b eop=%b mod=%0d", i,
                         obs_q[i].d, obs_q[i].sop, obs_q[i].eop, obs_q[i].mod, exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].mod);
            end
        end
        n_chk++; if (sop_cyc != 1) begin n_fail++; $display("FAIL arp_sop_latency: got %0d want 1", sop_cyc); end
        n_chk++; if (done_after !== 1'b1) begin n_fail++; $display("FAIL arp_done: got %b want 1", done_after); end
    endtask

    task automatic test_icmp();
        int lens [2] = '{32, 0};
        for (int k = 0; k < 2; k++) begin
            set_defaults(); reply = 8'h02; rnd_rdy = 1'b0; icmp_length = 16'(lens[k]);
            expect_icmp();
            run_frame(200, 1'b0);
            n_chk++; if (timed_out) begin n_fail++; $display("FAIL icmp%0d_timeout: no eop", lens[k]); end
            n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL icmp%0d_words: got %0d want %0d", lens[k], obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_chk++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL icmp%0d_w%0d: got %h sop=%b eop=%b mod=%0d want %h sop=%b eop=%b mod=%0d", lens[k], i,
                             obs_q[i].d, obs_q[i].sop, obs_q[i].eop, obs_q[i].mod, exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].mod);
                end
            end
            n_chk++; if (sop_cyc != 3) begin n_fail++; $display("FAIL icmp%0d_sop_latency: got %0d want 3", lens[k], sop_cyc); end
            n_chk++; if (done_after !== 1'b1) begin n_fail++; $display("FAIL icmp%0d_done: got %b want 1", lens[k], done_after); end
            if (obs_q.size() > 9) begin
                n_chk++;
                if (obs_q[9].d !== {16'hFFFE, 16'hBEEF}) begin n_fail++; $display("FAIL icmp%0d_icsum_word: got %h want fffebeef", lens[k], obs_q[9].d); end
            end
        end
    endtask

    task automatic test_stall();
        set_defaults(); reply = 8'h02; icmp_length = 16'd100; rnd_rdy = 1'b1;
        expect_icmp();
        run_frame(400, 1'b0);
        rnd_rdy = 1'b0;
        n_chk++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout: no eop within 400 clks"); end
        n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_words: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_w%0d: got %h sop=%b eop=%b mod=%0d want %h sop=%b eop=%b mod=%0d", i,
                         obs_q[i].d, obs_q[i].sop, obs_q[i].eop, obs_q[i].mod, exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].mod);
            end
        end
    endtask

    task automatic test_drop();
        int bad = 0;
        set_defaults(); reply = 8'h02; icmp_length = 16'd1473;
        @(posedge clk); #1 send = 1'b1;
        @(posedge clk); #1 send = 1'b0;
        @(negedge clk);
        n_chk++; if (drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b want 1", drop); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy); end
        repeat (20) begin
            @(negedge clk);
            if (tx_wren || busy || drop) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL drop_quiet: got %0d active clks want 0", bad); end
    endtask

    task automatic test_busy_ignore();
        int bad = 0;
        set_defaults(); reply = 8'h01; rnd_rdy = 1'b0;
        expect_arp();
        run_frame(100, 1'b1);
        n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ignore_words: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ignore_w%0d: got %h sop=%b eop=%b mod=%0d want %h sop=%b eop=%b mod=%0d", i,
                         obs_q[i].d, obs_q[i].sop, obs_q[i].eop, obs_q[i].mod, exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].mod);
            end
        end
        repeat (15) begin
            @(negedge clk);
            if (tx_wren || busy) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL ignore_no_second_frame: got %0d active clks want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        set_defaults(); reply = 8'h02; rnd_rdy = 1'b0;
        @(posedge clk); #1 send = 1'b1;
        @(posedge clk); #1 send = 1'b0;
        for (int c = 0; c < 50 && cnt < 5; c++) begin
            @(negedge clk);
            if (tx_wren && tx_rdy) cnt++;
        end
        n_chk++; if (cnt != 5) begin n_fail++; $display("FAIL rstmid_reach_w5: got %0d words want 5", cnt); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({tx_wren, tx_sop, tx_eop, tx_mod, busy, done, drop} !== 8'd0 || tx_data !== 32'd0 || mem_adr !== 11'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got wren=%b eop=%b busy=%b data=%h adr=%0d, want all zero",
                     tx_wren, tx_eop, busy, tx_data, mem_adr);
        end
        @(posedge clk); #1 rst = 1'b1;
        reply = 8'h01;
        expect_arp();
        run_frame(100, 1'b0);
        n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_words: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmid_w%0d: got %h want %h", i, obs_q[i].d, exp_q[i].d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lens [3] = '{5, -1, 13};
        for (int k = 0; k < 3; k++) begin
            set_defaults(); rnd_rdy = 1'b0;
            identification = 16'(16'h2000 + k); identifier = 16'hBEEF;
            if (lens[k] < 0) begin reply = 8'h03; expect_arp(); end
            else begin reply = 8'h02; icmp_length = 16'(lens[k]); expect_icmp(); end
            run_frame(200, 1'b0);
            n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b%0d_words: got %0d want %0d", k, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_chk++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b%0d_w%0d: got %h sop=%b eop=%b mod=%0d want %h sop=%b eop=%b mod=%0d", k, i,
                             obs_q[i].d, obs_q[i].sop, obs_q[i].eop, obs_q[i].mod, exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].mod);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        set_defaults();
        test_reset();
        test_arp();
        test_icmp();
        test_stall();
        test_drop();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
